// File: rtl/riscv_trace_pkg.sv
// Shared types for the trace collector: record kinds, record payload, counter width.
package riscv_trace_pkg;

    localparam int unsigned TRACE_DATA_W = 32;
    localparam int unsigned TRACE_ADDR_W = 9;
    localparam int unsigned DROP_CNT_W   = 16;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_REG   = 2'd1,
        KIND_STORE = 2'd2,
        KIND_LOAD  = 2'd3
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e                kind;
        logic [TRACE_ADDR_W-1:0]    tag;
        logic [TRACE_DATA_W-1:0]    data;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Dual-push / single-pop FIFO. push1 lands in the slot after push0 and is only
// meaningful when push0 is also enabled; the caller never overfills or underpops.
module trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter type         rec_t = trace_rec_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0_en,
    input  rec_t                     push0_rec,
    input  logic                     push1_en,
    input  rec_t                     push1_rec,
    input  logic                     pop_en,
    output rec_t                     head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_p1_c;
    logic [1:0]       n_push_c;

    // Second push slot and push count for this edge.
    always_comb begin
        wr_ptr_p1_c = wr_ptr + PTR_W'(1);
        n_push_c    = 2'(push0_en) + 2'(push1_en);
    end

    // Record storage; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (push0_en) mem[wr_ptr]      <= push0_rec;
        if (push1_en) mem[wr_ptr_p1_c] <= push1_rec;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push_c);
            rd_ptr <= rd_ptr + PTR_W'(pop_en);
            level  <= level + LVL_W'(n_push_c) - LVL_W'(pop_en);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/riscv_trace_collector.sv
// Trace sink for the core's write-back and data-memory debug ports.
// Optional feature macro: TRACE_MEM_EN (capture STORE/LOAD events; otherwise REG only).
module riscv_trace_collector
    import riscv_trace_pkg::*;
#(
    parameter int unsigned DATA_W = TRACE_DATA_W,
    parameter int unsigned ADDR_W = TRACE_ADDR_W,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reg_write_sig,
    input  logic [4:0]              reg_num,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_kind,
    output logic [ADDR_W-1:0]       out_tag,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = DROP_CNT_W + 1;

    logic             reg_ev_c;
    logic             mem_ev_c;
    trace_rec_t       reg_rec_c;
    trace_rec_t       mem_rec_c;
    trace_rec_t       push0_rec_c;
    trace_rec_t       head_rec;
    logic [LVL_W-1:0] free_c;
    logic [1:0]       n_ev_c;
    logic [1:0]       n_push_c;
    logic [1:0]       n_drop_c;
    logic             push0_c;
    logic             push1_c;
    logic             pop_c;
    logic [SUM_W-1:0] drop_sum_c;

`ifndef TRACE_MEM_EN
    logic unused_mem;
    assign unused_mem = ^{wr, rd, addr, wr_data, rd_data};
`endif

    // Event decode: x0 writes are not events; a simultaneous store wins over a load.
    always_comb begin
        reg_ev_c       = reg_write_sig && (reg_num != 5'd0);
        reg_rec_c.kind = KIND_REG;
        reg_rec_c.tag  = TRACE_ADDR_W'(reg_num);
        reg_rec_c.data = TRACE_DATA_W'(reg_data);
`ifdef TRACE_MEM_EN
        mem_ev_c       = wr || rd;
        mem_rec_c.kind = wr ? KIND_STORE : KIND_LOAD;
        mem_rec_c.tag  = TRACE_ADDR_W'(addr);
        mem_rec_c.data = wr ? TRACE_DATA_W'(wr_data) : TRACE_DATA_W'(rd_data);
`else
        mem_ev_c       = 1'b0;
        mem_rec_c      = '0;
`endif
    end

    // Admission: space is judged on the pre-edge level, REG (older instruction) first.
    always_comb begin
        free_c      = LVL_W'(DEPTH) - level;
        n_ev_c      = 2'(reg_ev_c) + 2'(mem_ev_c);
        push0_c     = (n_ev_c != 2'd0) && (free_c != '0);
        push1_c     = (n_ev_c == 2'd2) && (free_c >= LVL_W'(2));
        push0_rec_c = reg_ev_c ? reg_rec_c : mem_rec_c;
        n_push_c    = 2'(push0_c) + 2'(push1_c);
        n_drop_c    = n_ev_c - n_push_c;
        drop_sum_c  = {1'b0, drop_cnt} + SUM_W'(n_drop_c);
    end

    assign out_valid = (level != '0);
    assign pop_c     = out_valid && out_ready;

    trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (trace_rec_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push0_en  (push0_c),
        .push0_rec (push0_rec_c),
        .push1_en  (push1_c),
        .push1_rec (mem_rec_c),
        .pop_en    (pop_c),
        .head      (head_rec),
        .level     (level)
    );

    // Drop accounting: saturating counter plus sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (n_drop_c != 2'd0) begin
            overflow <= 1'b1;
            drop_cnt <= drop_sum_c[DROP_CNT_W] ? '1 : drop_sum_c[DROP_CNT_W-1:0];
        end
    end

    // Head presentation: zeroed whenever the buffer is empty.
    always_comb begin
        out_kind = '0;
        out_tag  = '0;
        out_data = '0;
        if (out_valid) begin
            out_kind = 2'(head_rec.kind);
            out_tag  = ADDR_W'(head_rec.tag);
            out_data = DATA_W'(head_rec.data);
        end
    end

endmodule

// File: tb/tb_riscv_trace_collector.sv
// Directed bench for riscv_trace_collector; expectations adapt to TRACE_MEM_EN.
module tb_riscv_trace_collector;

`ifdef TRACE_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [8:0]  out_tag;
    logic [31:0] out_data;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_trace_collector #(.DATA_W(32), .ADDR_W(9), .DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_kind      (out_kind),
        .out_tag       (out_tag),
        .out_data      (out_data),
        .level         (level),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write_sig = 1'b0; reg_num = 5'd0; reg_data = 32'd0;
        wr = 1'b0; rd = 1'b0; addr = 9'd0; wr_data = 32'd0; rd_data = 32'd0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && level != 5'd0; i++) tick();
        out_ready = 1'b0;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL drain_level: got %0d expected 0", level); end
    endtask

    task automatic test_reset();
        reset = 1'b0; out_ready = 1'b0; idle();
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data); end
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_single_reg();
        out_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
        tick(); idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
        n_checks++; if (out_kind !== 2'd1) begin n_fail++; $display("FAIL single_kind: got %0d expected 1", out_kind); end
        n_checks++; if (out_tag !== 9'd5) begin n_fail++; $display("FAIL single_tag: got %0h expected 5", out_tag); end
        n_checks++; if (out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %0h expected deadbeef", out_data); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %0b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL single_zero_data: got %0h expected 0", out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_dual_push();
        out_ready = 1'b0;
        reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'h11;
        wr = 1'b1; addr = 9'h040; wr_data = 32'h22;
        tick(); idle();
        n_checks++; if (level !== (MEM_EN ? 5'd2 : 5'd1)) begin n_fail++; $display("FAIL dual_level: got %0d expected %0d", level, MEM_EN ? 2 : 1); end
        n_checks++; if (out_kind !== 2'd1) begin n_fail++; $display("FAIL dual_head_kind: got %0d expected 1", out_kind); end
        n_checks++; if (out_tag !== 9'd3) begin n_fail++; $display("FAIL dual_head_tag: got %0h expected 3", out_tag); end
        n_checks++; if (out_data !== 32'h11) begin n_fail++; $display("FAIL dual_head_data: got %0h expected 11", out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_checks++; if (out_kind !== (MEM_EN ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL dual_second_kind: got %0d expected %0d", out_kind, MEM_EN ? 2 : 0); end
        n_checks++; if (out_tag !== (MEM_EN ? 9'h040 : 9'h000)) begin n_fail++; $display("FAIL dual_second_tag: got %0h expected %0h", out_tag, MEM_EN ? 9'h040 : 9'h000); end
        n_checks++; if (out_data !== (MEM_EN ? 32'h22 : 32'h0)) begin n_fail++; $display("FAIL dual_second_data: got %0h expected %0h", out_data, MEM_EN ? 32'h22 : 32'h0); end
        drain();
    endtask

    task automatic test_x0_and_both();
        out_ready = 1'b0;
        reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h99;
        wr = 1'b1; rd = 1'b1; addr = 9'h1AB; wr_data = 32'h33; rd_data = 32'h44;
        tick(); idle();
        n_checks++; if (level !== (MEM_EN ? 5'd1 : 5'd0)) begin n_fail++; $display("FAIL x0_level: got %0d expected %0d", level, MEM_EN ? 1 : 0); end
        n_checks++; if (out_kind !== (MEM_EN ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL x0_kind: got %0d expected %0d", out_kind, MEM_EN ? 2 : 0); end
        n_checks++; if (out_tag !== (MEM_EN ? 9'h1AB : 9'h000)) begin n_fail++; $display("FAIL x0_tag: got %0h expected %0h", out_tag, MEM_EN ? 9'h1AB : 9'h000); end
        n_checks++; if (out_data !== (MEM_EN ? 32'h33 : 32'h0)) begin n_fail++; $display("FAIL x0_data: got %0h expected %0h", out_data, MEM_EN ? 32'h33 : 32'h0); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL x0_drop: got %0d expected 0", drop_cnt); end
        drain();
    endtask

    task automatic test_fill_drop();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reg_write_sig = 1'b1; reg_num = 5'(i + 1); reg_data = 32'(100 + i);
            tick();
        end
        idle();
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level: got %0d expected 16", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf: got %0b expected 0", overflow); end
        reg_write_sig = 1'b1; reg_num = 5'd20; reg_data = 32'hAAAA;
        rd = 1'b1; addr = 9'h055; rd_data = 32'h77;
        tick(); idle();
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d expected 16", level); end
        n_checks++; if (drop_cnt !== (MEM_EN ? 16'd2 : 16'd1)) begin n_fail++; $display("FAIL full_drop: got %0d expected %0d", drop_cnt, MEM_EN ? 2 : 1); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %0b expected 1", overflow); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL pop_level: got %0d expected 15", level); end
        n_checks++; if (out_tag !== 9'd2) begin n_fail++; $display("FAIL pop_head_tag: got %0h expected 2", out_tag); end
        n_checks++; if (out_data !== 32'd101) begin n_fail++; $display("FAIL pop_head_data: got %0d expected 101", out_data); end
        reg_write_sig = 1'b1; reg_num = 5'd21; reg_data = 32'hBBBB;
        rd = 1'b1; addr = 9'h056; rd_data = 32'h78;
        tick(); idle();
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL one_free_level: got %0d expected 16", level); end
        n_checks++; if (drop_cnt !== (MEM_EN ? 16'd3 : 16'd1)) begin n_fail++; $display("FAIL one_free_drop: got %0d expected %0d", drop_cnt, MEM_EN ? 3 : 1); end
    endtask

    task automatic test_push_pop_full();
        out_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'hCCCC;
        tick(); idle(); out_ready = 1'b0;
        n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL pp_level: got %0d expected 15", level); end
        n_checks++; if (drop_cnt !== (MEM_EN ? 16'd4 : 16'd2)) begin n_fail++; $display("FAIL pp_drop: got %0d expected %0d", drop_cnt, MEM_EN ? 4 : 2); end
        n_checks++; if (out_tag !== 9'd3) begin n_fail++; $display("FAIL pp_head_tag: got %0h expected 3", out_tag); end
        n_checks++; if (out_data !== 32'd102) begin n_fail++; $display("FAIL pp_head_data: got %0d expected 102", out_data); end
    endtask

    task automatic test_reset_mid();
        #2 reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b expected 0", out_valid); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", level); end
        n_checks++; if (out_tag !== 9'd0) begin n_fail++; $display("FAIL mid_tag: got %0h expected 0", out_tag); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %0b expected 0", overflow); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_drop: got %0d expected 0", drop_cnt); end
        #2 reset = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd9; reg_data = 32'h1234;
        tick(); idle();
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL post_rst_level: got %0d expected 1", level); end
        n_checks++; if (out_tag !== 9'd9) begin n_fail++; $display("FAIL post_rst_tag: got %0h expected 9", out_tag); end
        n_checks++; if (out_data !== 32'h1234) begin n_fail++; $display("FAIL post_rst_data: got %0h expected 1234", out_data); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            reg_write_sig = 1'b1; reg_num = 5'(10 + i); reg_data = 32'h5000 + 32'(i);
            tick();
            n_checks++; if (out_data !== 32'h5000 + 32'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, out_data, 32'h5000 + 32'(i)); end
            n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL b2b_level[%0d]: got %0d expected 1", i, level); end
        end
        idle();
        tick();
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL b2b_final_level: got %0d expected 0", level); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_reg();
        test_dual_push();
        test_x0_and_both();
        test_fill_drop();
        test_push_pop_full();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
